// File: rtl/ldst_lane_responder.sv
// Memory-side responder for the per-lane load/store packet interface.
// Requests queue in order and run against a lane-local byte-enabled scratchpad.
module ldst_lane_responder #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 6,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_store_i,
  input  logic [ADDR_W+REG_W+DATA_W+3:0]  req_packet_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [REG_W-1:0]                wb_reg_o,
  output logic [DATA_W-1:0]               wb_data_o,
  output logic                            wb_err_o,
  output logic                            store_err_o,
  output logic                            busy_o
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned AL_W   = IDX_W + 2;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = 1 + AL_W + REG_W + DATA_W + 4;
  localparam int unsigned RG_LSB = DATA_W + 4;
  localparam int unsigned AD_LSB = DATA_W + REG_W + 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Only the address bits that reach the scratchpad are kept in the queue.
  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_c, pop_c;

  logic [1:0]        state_q, state_d;
  logic              wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              store_err_q, store_err_d;
  logic              ready_q, busy_q;

  logic [REG_W-1:0]  ld_reg_q, ld_reg_d;
  logic [1:0]        ld_off_q, ld_off_d, ld_size_q, ld_size_d;
  logic              ld_fault_q, ld_fault_d;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rd_data_q;
  logic              mem_we_c, rd_en_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c, lane_data_c;

  logic [ENT_W-1:0]  head_c;
  logic              h_store_c, h_fault_c;
  logic [AL_W-1:0]   h_addr_c;
  logic [REG_W-1:0]  h_reg_c;
  logic [DATA_W-1:0] h_data_c;
  logic [1:0]        h_space_c, h_size_c;
  logic [IDX_W-1:0]  h_idx_c;

  assign push_c = req_valid_i && req_ready_o;
  assign pop_c  = (state_q == IDLE) && (count_q != '0);

  assign head_c    = fifo_q[rd_ptr_q];
  assign h_store_c = head_c[ENT_W-1];
  assign h_addr_c  = head_c[AD_LSB +: AL_W];
  assign h_reg_c   = head_c[RG_LSB +: REG_W];
  assign h_data_c  = head_c[4 +: DATA_W];
  assign h_space_c = head_c[3:2];
  assign h_size_c  = head_c[1:0];
  assign h_idx_c   = h_addr_c[AL_W-1:2];

  assign h_fault_c = (h_space_c != 2'b00) || (h_size_c == 2'b11) ||
                     ((h_size_c == 2'b01) && h_addr_c[0]) ||
                     ((h_size_c == 2'b00) && (h_addr_c[1:0] != 2'b00));

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= {req_store_i,
                           req_packet_i[AD_LSB-(AL_W-AL_W) +: AL_W],
                           req_packet_i[RG_LSB +: REG_W],
                           req_packet_i[4 +: DATA_W],
                           req_packet_i[3:0]};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_c    = 4'hF;
    wdata_c = h_data_c;
    case (h_size_c)
      2'b10: begin
        be_c    = 4'b0001 << h_addr_c[1:0];
        wdata_c = {4{h_data_c[7:0]}};
      end
      2'b01: begin
        be_c    = h_addr_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{h_data_c[15:0]}};
      end
      default: begin
        be_c    = 4'hF;
        wdata_c = h_data_c;
      end
    endcase
  end

  // Load lane extraction from the registered RAM word.
  always_comb begin
    case (ld_size_q)
      2'b10:   lane_data_c = DATA_W'(rd_data_q[{ld_off_q, 3'b000} +: 8]);
      2'b01:   lane_data_c = DATA_W'(rd_data_q[{ld_off_q[1], 4'b0000} +: 16]);
      default: lane_data_c = rd_data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = wb_valid_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    store_err_d = 1'b0;
    ld_reg_d    = ld_reg_q;
    ld_off_d    = ld_off_q;
    ld_size_d   = ld_size_q;
    ld_fault_d  = ld_fault_q;
    mem_we_c    = 1'b0;
    rd_en_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_c) begin
          if (h_store_c) begin
            store_err_d = h_fault_c;
            mem_we_c    = !h_fault_c;
          end else begin
            ld_reg_d   = h_reg_c;
            ld_off_d   = h_addr_c[1:0];
            ld_size_d  = h_size_c;
            ld_fault_d = h_fault_c;
            rd_en_c    = 1'b1;
            state_d    = READ;
          end
        end
      end
      READ: begin
        wb_reg_d   = ld_reg_q;
        wb_err_d   = ld_fault_q;
        wb_data_d  = ld_fault_q ? '0 : lane_data_c;
        wb_valid_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      store_err_q <= 1'b0;
      ld_reg_q    <= '0;
      ld_off_q    <= '0;
      ld_size_q   <= '0;
      ld_fault_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      store_err_q <= store_err_d;
      ld_reg_q    <= ld_reg_d;
      ld_off_q    <= ld_off_d;
      ld_size_q   <= ld_size_d;
      ld_fault_q  <= ld_fault_d;
      ready_q     <= (count_d != DEPTH_C);
      busy_q      <= (count_d != '0) || (state_d != IDLE);
    end
  end

  // Scratchpad: byte-enabled write, synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[h_idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
    if (rd_en_c) rd_data_q <= mem_q[h_idx_c];
  end

  assign req_ready_o = ready_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_reg_o    = wb_reg_q;
  assign wb_data_o   = wb_data_q;
  assign wb_err_o    = wb_err_q;
  assign store_err_o = store_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ldst_lane_responder.sv
// Bench for ldst_lane_responder: vector table through a writeback scoreboard,
// plus latency, backpressure/full and mid-operation reset sequences.
module tb_ldst_lane_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, req_store_i;
  logic [73:0] req_packet_i;
  logic        wb_valid_o, wb_ready_i, wb_err_o, store_err_o, busy_o;
  logic [5:0]  wb_reg_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  ldst_lane_responder dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_store_i(req_store_i), .req_packet_i(req_packet_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o), .wb_err_o(wb_err_o),
    .store_err_o(store_err_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [5:0]  rg;
    logic [31:0] data;
    logic [1:0]  space;
    logic [1:0]  size;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [5:0]  rg;
    logic [31:0] data;
    logic        err;
  } wb_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  wb_t  sb [$];
  int   n_cmp = 0, n_fail = 0, n_wb = 0, n_serr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Writeback scoreboard and store-fault pulse counter.
  always @(negedge clk) begin
    wb_t e;
    if (reset) begin
      if (store_err_o) n_serr++;
      if (wb_valid_o && wb_ready_i) begin
        n_wb++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wb_unexpected: got reg %0d data %h with nothing expected", wb_reg_o, wb_data_o);
        end else begin
          e = sb.pop_front();
          check("wb_reg", 32'(wb_reg_o), 32'(e.rg));
          check("wb_data", wb_data_o, e.data);
          check("wb_err", 32'(wb_err_o), 32'(e.err));
        end
      end
    end
  end

  task automatic send_req(input logic st, input logic [31:0] addr, input logic [5:0] rg,
                          input logic [31:0] data, input logic [1:0] sp, input logic [1:0] sz,
                          input logic [31:0] ed, input logic ee);
    int n = 0;
    req_valid_i  = 1'b1;
    req_store_i  = st;
    req_packet_i = {addr, rg, data, sp, sz};
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: req_ready_o got 0 expected 1 within 200 cycles");
    end else begin
      if (!st) sb.push_back('{rg, ed, ee});
      @(negedge clk);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy_o got %0b pending %0d expected idle", busy_o, sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_serr = 0;
    int n, n0;
    reset = 1'b0;
    req_valid_i = 1'b0;
    req_store_i = 1'b0;
    req_packet_i = '0;
    wb_ready_i = 1'b1;

    vecs[0]  = '{1'b1, 32'h10,  6'd0,  32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  6'd5,  32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h12,  6'd6,  32'h0,        2'b00, 2'b10, 32'h000000AD, 1'b0};
    vecs[3]  = '{1'b0, 32'h12,  6'd7,  32'h0,        2'b00, 2'b01, 32'h0000DEAD, 1'b0};
    vecs[4]  = '{1'b1, 32'h11,  6'd0,  32'hFFFFFF55, 2'b00, 2'b10, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,  6'd8,  32'h0,        2'b00, 2'b00, 32'hDEAD55EF, 1'b0};
    vecs[6]  = '{1'b0, 32'h13,  6'd9,  32'h0,        2'b00, 2'b01, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h10,  6'd10, 32'h0,        2'b01, 2'b00, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h400, 6'd0,  32'h00001234, 2'b00, 2'b00, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h0,   6'd11, 32'h0,        2'b00, 2'b00, 32'h00001234, 1'b0};
    vecs[10] = '{1'b1, 32'h02,  6'd0,  32'hFFFFFFFF, 2'b00, 2'b00, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,   6'd12, 32'h0,        2'b00, 2'b00, 32'h00001234, 1'b0};
    vecs[12] = '{1'b1, 32'h12,  6'd0,  32'h1111CAFE, 2'b00, 2'b01, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h10,  6'd13, 32'h0,        2'b00, 2'b00, 32'hCAFE55EF, 1'b0};
    vecs[14] = '{1'b0, 32'h10,  6'd14, 32'h0,        2'b00, 2'b11, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h13,  6'd15, 32'h0,        2'b00, 2'b10, 32'h000000CA, 1'b0};
    vecs[16] = '{1'b1, 32'h10,  6'd0,  32'h00000077, 2'b10, 2'b10, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h10,  6'd16, 32'h0,        2'b00, 2'b00, 32'hCAFE55EF, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_store_err", 32'(store_err_o), 32'd0);
    check("rst_wb_reg", 32'(wb_reg_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_wb_err", 32'(wb_err_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].st && vecs[i].exp_err) exp_serr++;
      send_req(vecs[i].st, vecs[i].addr, vecs[i].rg, vecs[i].data, vecs[i].space,
               vecs[i].size, vecs[i].exp_data, vecs[i].exp_err);
    end
    wait_idle();
    check("store_err_pulses", 32'(n_serr), 32'(exp_serr));

    // Uniform three-cycle load latency, good and faulted.
    send_req(1'b0, 32'h10, 6'd17, 32'h0, 2'b00, 2'b00, 32'hCAFE55EF, 1'b0);
    n = 0;
    while (!wb_valid_o && n < 20) begin @(negedge clk); n++; end
    check("latency_ok", 32'(n), 32'd2);
    wait_idle();
    send_req(1'b0, 32'h10, 6'd18, 32'h0, 2'b10, 2'b00, 32'h0, 1'b1);
    n = 0;
    while (!wb_valid_o && n < 20) begin @(negedge clk); n++; end
    check("latency_fault", 32'(n), 32'd2);
    wait_idle();

    // Backpressure: five loads fill queue plus one in flight.
    @(posedge clk); #1 wb_ready_i = 1'b0;
    @(negedge clk);
    n0 = n_wb;
    send_req(1'b0, 32'h10, 6'd20, 32'h0, 2'b00, 2'b00, 32'hCAFE55EF, 1'b0);
    send_req(1'b0, 32'h11, 6'd21, 32'h0, 2'b00, 2'b10, 32'h00000055, 1'b0);
    send_req(1'b0, 32'h10, 6'd22, 32'h0, 2'b00, 2'b01, 32'h000055EF, 1'b0);
    send_req(1'b0, 32'h0,  6'd23, 32'h0, 2'b00, 2'b00, 32'h00001234, 1'b0);
    send_req(1'b0, 32'h13, 6'd24, 32'h0, 2'b00, 2'b10, 32'h000000CA, 1'b0);
    check("full_req_ready", 32'(req_ready_o), 32'd0);
    check("full_busy", 32'(busy_o), 32'd1);
    n = 0;
    while (!wb_valid_o && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      check("hold_wb_valid", 32'(wb_valid_o), 32'd1);
      check("hold_wb_reg", 32'(wb_reg_o), 32'd20);
      check("hold_wb_data", wb_data_o, 32'hCAFE55EF);
      check("hold_req_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 wb_ready_i = 1'b1;
    wait_idle();
    check("drain_count", 32'(n_wb - n0), 32'd5);

    // Reset while a writeback is pending with three requests queued.
    @(posedge clk); #1 wb_ready_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      send_req(1'b0, 32'h0, 6'(30 + k), 32'h0, 2'b00, 2'b00, 32'h00001234, 1'b0);
    n = 0;
    while (!wb_valid_o && n < 20) begin @(negedge clk); n++; end
    check("pre_reset_wb_valid", 32'(wb_valid_o), 32'd1);
    reset = 1'b0;
    #1;
    check("async_wb_valid", 32'(wb_valid_o), 32'd0);
    check("async_busy", 32'(busy_o), 32'd0);
    check("async_req_ready", 32'(req_ready_o), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wb_ready_i = 1'b1;
    n0 = n_wb;
    repeat (10) @(negedge clk);
    check("no_stale_wb", 32'(n_wb - n0), 32'd0);
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_ready", 32'(req_ready_o), 32'd1);
    send_req(1'b0, 32'h0, 6'd40, 32'h0, 2'b00, 2'b00, 32'h00001234, 1'b0);
    wait_idle();
    check("post_reset_load", 32'(n_wb - n0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
